// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared widths and state encoding for the mux scan controller
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;
endpackage

// File: rtl/mux_scan_if.sv
// mux_scan_if: control, mux-facing and sample-stream signals of the scan controller
interface mux_scan_if #(parameter int DWELL_W = 8) ();
  logic start;
  logic stop;
  logic mode;
  logic [3:0] mask;
  logic [DWELL_W-1:0] dwell;
  logic result;
  logic [1:0] select;
  logic sample_valid;
  logic [1:0] sample_ch;
  logic sample_bit;
  logic [3:0] snapshot;
  logic busy;
  logic done;
  modport master (
    input start, stop, mode, mask, dwell, result,
    output select, sample_valid, sample_ch, sample_bit, snapshot, busy, done
  );
  modport slave (
    output start, stop, mode, mask, dwell, result,
    input select, sample_valid, sample_ch, sample_bit, snapshot, busy, done
  );
endinterface

// File: rtl/mux_next_ch.sv
// mux_next_ch: circular priority finder over the channel enable mask
module mux_next_ch import mux_scan_pkg::*; (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt,
  output logic              last,
  output logic [CH_W-1:0]   first
);
  always_comb begin
    nxt = cur;
    first = '0;
    last = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) if (mask[i]) first = CH_W'(i);
    // smallest forward offset wins; offset 0 (cur itself) is the fallback
    for (int i = NUM_CH - 1; i >= 1; i--) if (mask[cur + CH_W'(i)]) nxt = cur + CH_W'(i);
    for (int i = 0; i < NUM_CH; i++) if (mask[i] && i > int'(cur)) last = 1'b0;
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan of a 4:1 mux with per-channel dwell and sample capture
module mux_scan_ctrl import mux_scan_pkg::*; #(
  parameter int DWELL_W = 8
) (
  input logic clk,
  input logic rst_n,
  mux_scan_if.master bus
);
  state_t state, state_n;
  logic [CH_W-1:0] sel, sel_n, sch, sch_n, nxt, first;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_l, dwell_n;
  logic [NUM_CH-1:0] mask_l, mask_n, snap, snap_n, fmask;
  logic mode_l, mode_n, sv, sv_n, sbit, sbit_n, busy, busy_n, done, done_n, last;
  // idle looks at the live mask to pick the start channel, scanning uses the latched one
  assign fmask = state == IDLE ? bus.mask : mask_l;
  mux_next_ch u_next (.mask(fmask), .cur(sel), .nxt, .last, .first);
  always_comb begin
    state_n = state;
    sel_n = sel;
    cnt_n = cnt;
    mask_n = mask_l;
    dwell_n = dwell_l;
    mode_n = mode_l;
    sv_n = 1'b0;
    done_n = 1'b0;
    sch_n = sch;
    sbit_n = sbit;
    snap_n = snap;
    busy_n = busy;
    if (bus.stop) begin
      state_n = IDLE;
      busy_n = 1'b0;
    end else if (state == IDLE) begin
      if (bus.start && |bus.mask) begin
        mask_n = bus.mask;
        dwell_n = bus.dwell;
        mode_n = bus.mode;
        sel_n = first;
        cnt_n = '0;
        state_n = DWELL;
        busy_n = 1'b1;
      end
    end else if (cnt != dwell_l) begin
      cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = '0;
      sv_n = 1'b1;
      sch_n = sel;
      sbit_n = bus.result;
      snap_n[sel] = bus.result;
      sel_n = last && !mode_l ? sel : nxt;
      done_n = last;
      state_n = last && !mode_l ? IDLE : DWELL;
      busy_n = !(last && !mode_l);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      mask_l <= '0;
      dwell_l <= '0;
      mode_l <= 1'b0;
      sv <= 1'b0;
      done <= 1'b0;
      sch <= '0;
      sbit <= 1'b0;
      snap <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      cnt <= cnt_n;
      mask_l <= mask_n;
      dwell_l <= dwell_n;
      mode_l <= mode_n;
      sv <= sv_n;
      done <= done_n;
      sch <= sch_n;
      sbit <= sbit_n;
      snap <= snap_n;
      busy <= busy_n;
    end
  assign bus.select = sel;
  assign bus.sample_valid = sv;
  assign bus.sample_ch = sch;
  assign bus.sample_bit = sbit;
  assign bus.snapshot = snap;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
